// File: rtl/demod_segment_sched.sv
// Sequences one shared nearest-reference slicer over NSEG samples; each sample is decided on the cycle it is accepted, and valid pulses once per burst.
// Backpressure: in_ready is high only while collecting. Define DEMOD_SOFT_METRIC_EN to add the saturating soft_metric accumulator output.
module demod_segment_sched #(
   parameter int                 NSEG  = 10,
   parameter logic signed [31:0] REF_P = 32'h0001_0000,
   parameter logic signed [31:0] REF_N = 32'hFFFF_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [31:0]     input_bit,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [NSEG-1:0] seg_bits,
   output logic [4:0]      seg_idx,
   output logic            valid,
`ifdef DEMOD_SOFT_METRIC_EN
   output logic [37:0]     soft_metric,
`endif
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        xfer;
   logic        last_seg;
   logic        start_acc;

   logic [31:0] ref_sel;
   logic [31:0] ref_opp;
   logic [32:0] x_ext;
   logic [32:0] dp;
   logic [32:0] dm;
   logic [32:0] mag_dp;
   logic [32:0] mag_dm;
   logic        dec_bit;
   logic [32:0] min_mag;

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      valid      = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = S_COLLECT;
            end
         end
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && last_seg) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            valid      = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

   assign xfer      = (state == S_COLLECT) && in_valid;
   assign start_acc = (state == S_IDLE) && start;
   assign last_seg  = (seg_idx == 5'(NSEG - 1));

   // ---------------------------------------------------------------
   // Shared decision datapath. 33-bit sign-extended differences cannot
   // overflow for any 32-bit sample against a +/-1.0 reference.
   // ---------------------------------------------------------------
   always_comb begin
      ref_sel = seg_idx[0] ? REF_N : REF_P;
      ref_opp = seg_idx[0] ? REF_P : REF_N;
      x_ext   = {input_bit[31], input_bit};
      dp      = x_ext - {ref_sel[31], ref_sel};
      dm      = x_ext - {ref_opp[31], ref_opp};
      mag_dp  = dp[32] ? (~dp + 33'd1) : dp;
      mag_dm  = dm[32] ? (~dm + 33'd1) : dm;
      dec_bit = (mag_dp < mag_dm);
      min_mag = dec_bit ? mag_dp : mag_dm;
   end

   // ---------------------------------------------------------------
   // Segment index and result word
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_idx  <= 5'd0;
         seg_bits <= '0;
      end else if (start_acc) begin
         seg_idx  <= 5'd0;
         seg_bits <= '0;
      end else if (xfer) begin
         for (int i = 0; i < NSEG; i++) begin
            if (seg_idx == 5'(i)) begin
               seg_bits[i] <= dec_bit;
            end
         end
         // Wrap on the final segment so the block is back at 0 for IDLE.
         seg_idx <= last_seg ? 5'd0 : seg_idx + 5'd1;
      end
   end

`ifdef DEMOD_SOFT_METRIC_EN
   logic [38:0] metric_sum;

   assign metric_sum = {1'b0, soft_metric} + {6'd0, min_mag};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         soft_metric <= '0;
      end else if (start_acc) begin
         soft_metric <= '0;
      end else if (xfer) begin
         soft_metric <= metric_sum[38] ? '1 : metric_sum[37:0];
      end
   end
`else
   // Minimum distance only feeds the optional accumulator.
   logic unused_min;
   assign unused_min = ^min_mag;
`endif

endmodule

// File: tb/tb_demod_segment_sched.sv
// Randomized bench for demod_segment_sched, checked against a distance-based model of the slicer.
module tb_demod_segment_sched;

   localparam int NSEG = 10;

   logic            clk;
   logic            reset;
   logic            start;
   logic [31:0]     input_bit;
   logic            in_valid;
   logic            in_ready;
   logic [NSEG-1:0] seg_bits;
   logic [4:0]      seg_idx;
   logic            valid;
   logic            busy;
`ifdef DEMOD_SOFT_METRIC_EN
   logic [37:0]     soft_metric;
`endif

   int checks = 0;
   int passed = 0;

   logic [31:0] samp [NSEG];

   demod_segment_sched #(.NSEG(NSEG)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .input_bit   (input_bit),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .seg_bits    (seg_bits),
      .seg_idx     (seg_idx),
      .valid       (valid),
`ifdef DEMOD_SOFT_METRIC_EN
      .soft_metric (soft_metric),
`endif
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Nearest of {+1.0, -1.0}: bit is 1 when the segment's own reference is strictly nearer.
   function automatic void model(output logic [NSEG-1:0] bits, output longint metric);
      longint x, r, a, b;
      bits   = '0;
      metric = 0;
      for (int i = 0; i < NSEG; i++) begin
         x = longint'($signed(samp[i]));
         r = (i % 2 == 0) ? 65536 : -65536;
         a = x - r;  if (a < 0) a = -a;
         b = x + r;  if (b < 0) b = -b;
         bits[i] = (a < b);
         metric += (a < b) ? a : b;
      end
      if (metric > 64'h3F_FFFF_FFFF) metric = 64'h3F_FFFF_FFFF;
   endfunction

   function automatic logic [31:0] rnd_sample();
      case ($urandom_range(0, 8))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h0000_0000;
         3: return 32'h0000_8000;
         4: return 32'hFFFF_8000;
         5: return 32'h0001_0000;
         6: return 32'hFFFF_0000;
         7: return $urandom_range(0, 32'h0003_0000) - 32'h0001_8000;
         default: return $urandom;
      endcase
   endfunction

   // Drives one burst from IDLE; lat counts cycles with the start-capture edge as cycle 1.
   task automatic run_burst(input bit gapped, input bit poke, output int lat,
                            output logic [NSEG-1:0] bits, output int busy_cnt,
                            output logic [37:0] metric);
      int  k;
      bit  drove;
      lat      = -1;
      bits     = '0;
      busy_cnt = 0;
      metric   = '0;
      k        = 0;
      start    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      for (int c = 1; c <= 200; c++) begin
         drove     = (gapped ? (c % 2 == 1) : 1'b1) && (k < NSEG);
         in_valid  = drove;
         input_bit = drove ? samp[k] : $urandom;
         start     = poke && (c == 5);
         @(posedge clk); #1;
         start = 1'b0;
         if (drove) k++;
         if (busy) busy_cnt++;
         if (valid) begin
            lat  = c + 1;
            bits = seg_bits;
`ifdef DEMOD_SOFT_METRIC_EN
            metric = soft_metric;
`endif
            break;
         end
      end
      in_valid = 1'b0;
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; input_bit = '0;
      #3;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else passed++;
      checks++; if (seg_idx !== 5'd0) $display("FAIL reset_seg_idx got=%0d want=0", seg_idx); else passed++;
      checks++; if (seg_bits !== '0) $display("FAIL reset_seg_bits got=%h want=0", seg_bits); else passed++;
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_pattern(input string name, input int kind);
      logic [NSEG-1:0] exp_bits, got_bits;
      longint exp_m;
      logic [37:0] got_m;
      int lat, bc;
      for (int i = 0; i < NSEG; i++)
         case (kind)
            0: samp[i] = (i % 2 == 0) ? 32'h0000_8000 : 32'hFFFF_8000;
            1: samp[i] = 32'h0000_8000;
            2: samp[i] = 32'h0000_0000;
            default: samp[i] = rnd_sample();
         endcase
      model(exp_bits, exp_m);
      run_burst(1'b0, 1'b0, lat, got_bits, bc, got_m);
      checks++; if (lat != NSEG + 1) $display("FAIL %s_latency got=%0d want=%0d", name, lat, NSEG + 1); else passed++;
      checks++; if (got_bits !== exp_bits) $display("FAIL %s_bits got=%h want=%h", name, got_bits, exp_bits); else passed++;
      checks++; if (bc != NSEG + 1) $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, NSEG + 1); else passed++;
`ifdef DEMOD_SOFT_METRIC_EN
      checks++; if (got_m !== 38'(exp_m)) $display("FAIL %s_metric got=%0d want=%0d", name, got_m, exp_m); else passed++;
`endif
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || valid !== 1'b0)
         $display("FAIL %s_idle_after got=busy%b/valid%b want=0/0", name, busy, valid); else passed++;
      checks++; if (seg_bits !== exp_bits) $display("FAIL %s_hold got=%h want=%h", name, seg_bits, exp_bits); else passed++;
   endtask

   task automatic test_gapped();
      logic [NSEG-1:0] exp_bits, got_bits;
      longint exp_m;
      logic [37:0] got_m;
      int lat, bc;
      for (int i = 0; i < NSEG; i++) samp[i] = rnd_sample();
      model(exp_bits, exp_m);
      run_burst(1'b1, 1'b0, lat, got_bits, bc, got_m);
      checks++; if (lat != 2 * NSEG) $display("FAIL gapped_latency got=%0d want=%0d", lat, 2 * NSEG); else passed++;
      checks++; if (got_bits !== exp_bits) $display("FAIL gapped_bits got=%h want=%h", got_bits, exp_bits); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (seg_idx !== 5'd0 || in_ready !== 1'b1)
         $display("FAIL stall_hold got=idx%0d/rdy%b want=0/1", seg_idx, in_ready); else passed++;
      in_valid = 1'b1; input_bit = 32'h0000_8000;
      @(posedge clk); #1; in_valid = 1'b0;
      checks++; if (seg_idx !== 5'd1) $display("FAIL stall_advance got=%0d want=1", seg_idx); else passed++;
      checks++; if (seg_bits[0] !== 1'b1) $display("FAIL stall_bit0 got=%b want=1", seg_bits[0]); else passed++;
      reset = 1'b1; #2; reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         input_bit = 32'h0000_8000;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (seg_idx !== 5'd4) $display("FAIL midreset_pre_idx got=%0d want=4", seg_idx); else passed++;
      #2; reset = 1'b1; #1;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || valid !== 1'b0)
         $display("FAIL midreset_ctrl got=%b%b%b want=000", busy, in_ready, valid); else passed++;
      checks++; if (seg_idx !== 5'd0 || seg_bits !== '0)
         $display("FAIL midreset_data got=idx%0d/bits%h want=0/0", seg_idx, seg_bits); else passed++;
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1;
      test_pattern("after_reset", 3);
   endtask

   task automatic test_start_ignored();
      logic [NSEG-1:0] exp_bits, got_bits;
      longint exp_m;
      logic [37:0] got_m;
      int lat, bc, extra;
      for (int i = 0; i < NSEG; i++) samp[i] = rnd_sample();
      model(exp_bits, exp_m);
      run_burst(1'b0, 1'b1, lat, got_bits, bc, got_m);
      checks++; if (lat != NSEG + 1) $display("FAIL poke_latency got=%0d want=%0d", lat, NSEG + 1); else passed++;
      checks++; if (got_bits !== exp_bits) $display("FAIL poke_bits got=%h want=%h", got_bits, exp_bits); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL poke_done_start busy got=%b want=0", busy); else passed++;
      extra = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 15; c++) begin
         input_bit = $urandom;
         @(posedge clk); #1;
         if (valid || busy) extra++;
      end
      in_valid = 1'b0;
      checks++; if (extra != 0) $display("FAIL poke_no_second got=%0d want=0", extra); else passed++;
   endtask

   initial begin
      test_reset();
      test_pattern("alternating", 0);
      test_pattern("all_pos", 1);
      test_pattern("ties", 2);
      test_gapped();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      for (int r = 0; r < 6; r++) test_pattern("random", 3);
      for (int r = 0; r < 2; r++) test_gapped();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
